// File: rtl/memory_router.sv
// Single-outstanding address router: decodes a CPU request onto one of SLAVES ports,
// waits for that slave's response, and returns decode/timeout errors itself.
module memory_router #(
  parameter int                     SLAVES     = 2,
  parameter logic [SLAVES*32-1:0]   SLAVE_BASE = {32'h0200_0000, 32'h0000_0000},
  parameter logic [SLAVES*32-1:0]   SLAVE_MASK = {32'hFFFF_0000, 32'hFF00_0000},
  parameter int                     TIMEOUT    = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memory_valid,
  input  logic                     memory_instr,
  input  logic [31:0]              memory_addr,
  input  logic [31:0]              memory_wdata,
  input  logic [3:0]               memory_wstrb,
  output logic [31:0]              memory_rdata,
  output logic                     memory_ready,
  output logic                     memory_error,
  output logic [SLAVES-1:0]        slave_valid,
  output logic                     slave_instr,
  output logic [31:0]              slave_addr,
  output logic [31:0]              slave_wdata,
  output logic [3:0]               slave_wstrb,
  input  logic [SLAVES*32-1:0]     slave_rdata,
  input  logic [SLAVES-1:0]        slave_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [SW-1:0]       r_sel;
  logic [SW-1:0]       w_sel_nxt;

  logic                w_hit;
  logic [SW-1:0]       w_idx;
  logic [SLAVES-1:0]   w_onehot;
  logic                w_sel_ready;
  logic [31:0]         w_sel_rdata;

  assign slave_instr = memory_instr;
  assign slave_addr  = memory_addr;
  assign slave_wdata = memory_wdata;
  assign slave_wstrb = memory_wstrb;

  // Scan from the top index down so the lowest matching slave is the one left standing.
  always_comb begin
    w_hit    = 1'b0;
    w_idx    = '0;
    w_onehot = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if ((memory_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        w_hit       = 1'b1;
        w_idx       = SW'(i);
        w_onehot    = '0;
        w_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (r_sel == SW'(i)) begin
        w_sel_ready = slave_ready[i];
        w_sel_rdata = slave_rdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sel_nxt    = r_sel;
    memory_ready = 1'b0;
    memory_error = 1'b0;
    memory_rdata = '0;
    slave_valid  = '0;
    case (r_state)
      S_IDLE: begin
        if (memory_valid) begin
          if (w_hit) begin
            slave_valid = w_onehot;
            w_sel_nxt   = w_idx;
            w_cnt_nxt   = '0;
            w_state_nxt = S_BUSY;
          end else begin
            w_state_nxt = S_ERR;
          end
        end
      end
      S_BUSY: begin
        // A response landing on the timeout cycle still wins over the error.
        if (w_sel_ready) begin
          memory_ready = 1'b1;
          memory_rdata = w_sel_rdata;
          w_state_nxt  = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          memory_ready = 1'b1;
          memory_error = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_ERR: begin
        memory_ready = 1'b1;
        memory_error = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // The response being dropped by reset must not leak out on the reset cycle itself.
    if (rst) begin
      memory_ready = 1'b0;
      memory_error = 1'b0;
      memory_rdata = '0;
    end
  end

endmodule

// File: tb/tb_memory_router.sv
// Bench for memory_router: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_memory_router;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memory_valid;
  logic        memory_instr;
  logic [31:0] memory_addr;
  logic [31:0] memory_wdata;
  logic [3:0]  memory_wstrb;
  logic [31:0] memory_rdata;
  logic        memory_ready;
  logic        memory_error;
  logic [1:0]  slave_valid;
  logic        slave_instr;
  logic [31:0] slave_addr;
  logic [31:0] slave_wdata;
  logic [3:0]  slave_wstrb;
  logic [63:0] slave_rdata;
  logic [1:0]  slave_ready;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Slave 0 region is non-contiguous so that 0x0200_0000 overlaps slave 1
  // while 0x0200_4000 belongs to slave 1 alone.
  logic [31:0] m_base [2] = '{32'h0000_0000, 32'h0200_0000};
  logic [31:0] m_mask [2] = '{32'hFC00_4000, 32'hFFFF_0000};

  memory_router #(
    .SLAVES    (2),
    .SLAVE_BASE({32'h0200_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hFFFF_0000, 32'hFC00_4000}),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .memory_valid(memory_valid),
    .memory_instr(memory_instr),
    .memory_addr (memory_addr),
    .memory_wdata(memory_wdata),
    .memory_wstrb(memory_wstrb),
    .memory_rdata(memory_rdata),
    .memory_ready(memory_ready),
    .memory_error(memory_error),
    .slave_valid (slave_valid),
    .slave_instr (slave_instr),
    .slave_addr  (slave_addr),
    .slave_wdata (slave_wdata),
    .slave_wstrb (slave_wstrb),
    .slave_rdata (slave_rdata),
    .slave_ready (slave_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 2; i++)
      if ((a & m_mask[i]) == m_base[i]) return i;
    return -1;
  endfunction

  // Transaction model: 0 = nothing outstanding, 1 = waiting on slave, 2 = decode error pending.
  int          m_out = 0;
  int          m_sel = 0;
  int          m_t0  = 0;
  int          m_cyc = 0;
  logic [1:0]  exp_sv;
  logic        exp_rdy, exp_err;
  logic [31:0] exp_rd;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        int nxt;
        int k;
        m_cyc++;
        exp_sv = '0; exp_rdy = 1'b0; exp_err = 1'b0; exp_rd = '0;
        nxt = m_out;
        case (m_out)
          0: if (memory_valid) begin
               k = decode(memory_addr);
               if (k >= 0) begin
                 exp_sv[k] = 1'b1;
                 m_sel = k;
                 m_t0  = m_cyc;
                 nxt   = 1;
               end else begin
                 nxt = 2;
               end
             end
          1: if (slave_ready[m_sel]) begin
               exp_rdy = 1'b1;
               exp_rd  = slave_rdata[32*m_sel +: 32];
               nxt     = 0;
             end else if (m_cyc - m_t0 >= TO) begin
               exp_rdy = 1'b1;
               exp_err = 1'b1;
               nxt     = 0;
             end
          default: begin
            exp_rdy = 1'b1;
            exp_err = 1'b1;
            nxt     = 0;
          end
        endcase
        if (rst) begin
          exp_rdy = 1'b0; exp_err = 1'b0; exp_rd = '0;
          nxt = 0;
        end
        chk("slave_valid", 64'(slave_valid), 64'(exp_sv));
        chk("memory_ready", 64'(memory_ready), 64'(exp_rdy));
        chk("memory_error", 64'(memory_error), 64'(exp_err));
        chk("memory_rdata", 64'(memory_rdata), 64'(exp_rd));
        chk("slave_fields", {slave_instr, slave_wstrb, slave_wdata, slave_addr[26:0]},
            {memory_instr, memory_wstrb, memory_wdata, memory_addr[26:0]});
        chk("slave_addr_hi", 64'(slave_addr[31:27]), 64'(memory_addr[31:27]));
        m_out = nxt;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    memory_valid = 1'b0;
    memory_instr = 1'b0;
    memory_addr  = '0;
    memory_wdata = '0;
    memory_wstrb = '0;
    slave_ready  = '0;
    slave_rdata  = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    step();
    chk_en = 1'b1;
    peek();
    chk("reset_ready", 64'(memory_ready), 64'd0);
    chk("reset_sv", 64'(slave_valid), 64'd0);
    step(); rst = 1'b0;

    // Read to slave 0, answered two cycles after the request
    step(); memory_valid = 1'b1; memory_addr = 32'h0000_0100;
    peek(); chk("rd_sv", 64'(slave_valid), 64'h1); chk("rd_early_ready", 64'(memory_ready), 64'd0);
    step(); memory_valid = 1'b0;
    peek(); chk("rd_sv_once", 64'(slave_valid), 64'd0);
    step(); slave_ready = 2'b01; slave_rdata[31:0] = 32'hDEAD_BEEF;
    peek(); chk("rd_resp", {memory_ready, memory_error, memory_rdata}, {1'b1, 1'b0, 32'hDEAD_BEEF});
    step(); idle_in();

    // Write to slave 1, answered next cycle
    step(); memory_valid = 1'b1; memory_addr = 32'h0200_4000; memory_wdata = 32'hCAFE_F00D; memory_wstrb = 4'hF;
    peek(); chk("wr_sv", 64'(slave_valid), 64'h2); chk("wr_fields", {slave_wdata, slave_wstrb}, {32'hCAFE_F00D, 4'hF});
    step(); idle_in(); slave_ready = 2'b10; slave_rdata[63:32] = 32'h0BAD_0BAD;
    peek(); chk("wr_resp", {memory_ready, memory_error}, 2'b10);
    step(); idle_in();

    // Unmapped address
    step(); memory_valid = 1'b1; memory_addr = 32'h8000_0000;
    peek(); chk("dec_sv", 64'(slave_valid), 64'd0); chk("dec_no_comb_ready", 64'(memory_ready), 64'd0);
    step(); idle_in();
    peek(); chk("dec_resp", {memory_ready, memory_error, memory_rdata}, {1'b1, 1'b1, 32'd0});
    step();
    peek(); chk("dec_idle", 64'(memory_ready), 64'd0);

    // Timeout with a late response two cycles after it
    step(); memory_valid = 1'b1; memory_addr = 32'h0000_0200;
    peek(); chk("to_sv", 64'(slave_valid), 64'h1);
    for (int i = 1; i < TO; i++) begin
      step(); memory_valid = 1'b0;
      peek(); chk("to_wait", 64'(memory_ready), 64'd0);
    end
    step();
    peek(); chk("to_resp", {memory_ready, memory_error, memory_rdata}, {1'b1, 1'b1, 32'd0});
    step();
    step(); slave_ready = 2'b01; slave_rdata[31:0] = 32'h7777_7777;
    peek(); chk("to_late_ignored", 64'(memory_ready), 64'd0);
    step(); idle_in();

    // Reset in the middle of a transaction
    step(); memory_valid = 1'b1; memory_addr = 32'h0200_4000;
    peek(); chk("rst_sv", 64'(slave_valid), 64'h2);
    step(); memory_valid = 1'b0; rst = 1'b1;
    peek(); chk("rst_mid_ready", 64'(memory_ready), 64'd0);
    step(); rst = 1'b0; slave_ready = 2'b10; slave_rdata[63:32] = 32'h0000_1234;
    peek(); chk("rst_late_ignored", 64'(memory_ready), 64'd0);
    step(); idle_in(); memory_valid = 1'b1; memory_addr = 32'h0000_0100;
    peek(); chk("rst_next_sv", 64'(slave_valid), 64'h1);
    step(); idle_in(); slave_ready = 2'b01; slave_rdata[31:0] = 32'h0000_0055;
    peek(); chk("rst_next_resp", {memory_ready, memory_rdata}, {1'b1, 32'h55});
    step(); idle_in();

    // Overlapping regions: lowest index wins, other slave's ready ignored
    step(); memory_valid = 1'b1; memory_addr = 32'h0200_0000;
    peek(); chk("ovl_sv", 64'(slave_valid), 64'h1);
    step(); idle_in(); slave_ready = 2'b10; slave_rdata = {32'h1111_1111, 32'h2222_2222};
    peek(); chk("ovl_other_ignored", 64'(memory_ready), 64'd0);
    step(); slave_ready = 2'b01; slave_rdata[31:0] = 32'h0000_A5A5;
    peek(); chk("ovl_resp", {memory_ready, memory_error, memory_rdata}, {1'b1, 1'b0, 32'h0000_A5A5});
    step(); idle_in();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r;
      step();
      r = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      memory_valid = rst ? 1'b0 : ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: memory_addr = {16'h0000, r[15:0]};
        1: memory_addr = {16'h0200, r[15:0]};
        2: memory_addr = 32'h8000_0000 | r;
        3: memory_addr = r;
        default: memory_addr = 32'h0200_0000;
      endcase
      memory_instr = $urandom_range(0, 1) == 1;
      memory_wdata = $urandom;
      memory_wstrb = 4'($urandom_range(0, 15));
      slave_ready[0] = ($urandom_range(0, 3) == 0);
      slave_ready[1] = ($urandom_range(0, 3) == 0);
      slave_rdata = {32'($urandom), 32'($urandom)};
    end
    step(); rst = 1'b0; idle_in();
    for (int i = 0; i < 8; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
